fp_mac_sequencer: RTL and testbench
===================================

Name: fp_mac_sequencer

Overview:
- Controller in front of the 5-stage floating-point MAC pipeline.
- Accepts a dot-product job of `vec_len` operand pairs and issues one pair per cycle into the pipeline, tagged first/last.
- Tracks in-flight work with a valid shift register matching pipeline depth.
- Captures the final accumulated value and sign when the last element leaves stage 5, then presents it on a valid/ready result port.

Parameters:
- PIPE_DEPTH, 5, cycles from `mac_issue` to that element's result at the adder-status stage output.
- LEN_W, 8, width of the vector-length field.
- DATA_W, 32, floating-point word width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  job start pulse; accepted only in IDLE.
- vec_len  in  LEN_W  number of operand pairs; sampled when `start` is accepted.
- busy  out  1  high in every state except IDLE.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  sequencer can take a pair.
- in_a, in_b  in  DATA_W  operand pair.
- mac_issue  out  1  pair presented to pipeline this cycle.
- mac_a, mac_b  out  DATA_W  operands to pipeline (registered).
- mac_acc_clear  out  1  qualifies `mac_issue`: this element starts a new accumulation.
- mac_result  in  DATA_W  pipeline stage-5 accumulated value.
- mac_sign  in  1  pipeline stage-5 sign status.
- out_valid  out  1  result held.
- out_ready  in  1  result consumer accepts.
- out_result  out  DATA_W  captured result.
- out_sign  out  1  captured sign.

Behaviour:
- Reset is asynchronous and active-high. On reset:
  - state = IDLE.
  - All outputs are 0.
  - Remaining-count, in-flight shift register, result and sign registers are all cleared.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - `in_ready`=0, `busy`=0.
  - `start` with `vec_len`≠0: latch `remaining`=`vec_len`, set `first_flag`, go to ISSUE.
  - `start` with `vec_len`=0: go straight to DONE with `out_result`=0, `out_sign`=0; nothing is issued.
- ISSUE:
  - `in_ready`=1.
  - On `in_valid` && `in_ready`:
    - Register `in_a`/`in_b` to `mac_a`/`mac_b` and pulse `mac_issue` the next cycle.
    - `mac_acc_clear`=`first_flag`; clear `first_flag`.
    - Decrement `remaining`.
  - When the accepted pair is the last (`remaining`==1): deassert `in_ready` from the next cycle and go to DRAIN.
  - Bubbles (`in_valid`=0) are allowed. They shift a 0 into the in-flight register; no timeout.
- In-flight register:
  - PIPE_DEPTH bits, each tagged with a last-bit.
  - Shifts every cycle; bit 0 = `mac_issue`.
  - The tap at depth PIPE_DEPTH marks the cycle in which `mac_result`/`mac_sign` belong to that element.
- DRAIN:
  - `in_ready`=0.
  - When the tagged-last element reaches the tap: capture `mac_result` → `out_result` and `mac_sign` → `out_sign`; set `out_valid`; go to DONE.
  - Latency from acceptance of the last pair to `out_valid` = PIPE_DEPTH+2 cycles.
- DONE:
  - `out_valid` held, with `out_result`/`out_sign` stable, until `out_ready`.
  - On the handshake: clear `out_valid`, go to IDLE the next cycle.
  - `out_ready` already high on entry completes the handshake in the first DONE cycle.
- `start` outside IDLE is ignored (no queueing).
- `in_valid` outside ISSUE is ignored; operands are not consumed.
- `vec_len` = 2^LEN_W−1 must work; `remaining` never wraps below 0.
- Reset asserted mid-job aborts the job, discards in-flight tags, and returns to IDLE with `out_valid`=0. The pipeline itself is reset by the same signal.

Optional Feature:
- Macro: FP_MAC_SEQ_PERF_EN.
- Defined:
  - Adds output `perf_cycles` [15:0], the count of cycles from `start` acceptance to `out_valid` rise.
  - Saturates at 16'hFFFF.
  - Cleared on accepted `start`; held until the next job.
  - Reset value 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package `fp_mac_pkg` holds:
  - the state encoding enum (IDLE=0, ISSUE=1, DRAIN=2, DONE=3);
  - PIPE_DEPTH default constant;
  - DATA_W constant.
- One sub-module: `fp_mac_inflight_tracker`, the PIPE_DEPTH-deep valid+last shift register with a tap output.

Test Plan:
- Reset mid-DRAIN (job vec_len=4, reset asserted 2 cycles after last accept) -> state IDLE, `out_valid`=0, no capture; next job of vec_len=1 completes correctly.
- vec_len=3, `in_valid` held high -> three `mac_issue` pulses in consecutive cycles, `mac_acc_clear` only on the first; `out_valid` exactly PIPE_DEPTH+2 cycles after the third accept; `out_result`/`out_sign` equal stage-5 model values.
- vec_len=4 with `in_valid` toggling 1,0,1,0,... -> 4 issues over 7 cycles; result captured only when the last-tagged element hits the tap; no early capture on bubbles.
- vec_len=0 -> `busy` for one cycle; DONE with `out_result`=0, `out_sign`=0; zero `mac_issue` pulses.
- DONE with `out_ready` low for 5 cycles, plus `start` pulsed during DONE -> `out_valid` and data stable for all 5 cycles; `start` ignored; IDLE after the handshake.
- With FP_MAC_SEQ_PERF_EN defined, vec_len=2 back-to-back -> `perf_cycles`=PIPE_DEPTH+4.

Source files
------------

// File: rtl/fp_mac_pkg.sv
// fp_mac_pkg: shared state encoding and default sizes for the FP MAC sequencer
// Contents: state_t (IDLE/ISSUE/DRAIN/DONE), PIPE_DEPTH_DEF, DATA_W.
package fp_mac_pkg;
  localparam int PIPE_DEPTH_DEF = 5;
  localparam int DATA_W = 32;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/fp_mac_inflight_tracker.sv
// fp_mac_inflight_tracker: valid+last shift register mirroring the MAC pipeline depth
// Ports: clock, reset (async, active-high); issue/last enter bit 0 each cycle;
// tap_valid/tap_last mark the cycle in which the pipeline output belongs to that element.
module fp_mac_inflight_tracker #(
  parameter int DEPTH = fp_mac_pkg::PIPE_DEPTH_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic issue,
  input  logic last,
  output logic tap_valid,
  output logic tap_last
);
  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] l;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      v <= '0;
      l <= '0;
    end else begin
      v <= {v[DEPTH-2:0], issue};
      l <= {l[DEPTH-2:0], issue & last};
    end
  assign tap_valid = v[DEPTH-1];
  assign tap_last  = l[DEPTH-1];
endmodule

// File: rtl/fp_mac_sequencer.sv
// fp_mac_sequencer: issues a dot-product job into the 5-stage FP MAC pipeline and returns its result
// Ports: clock, reset (async, active-high); start/vec_len/busy job control;
// in_valid/in_ready/in_a/in_b operand stream; mac_* pipeline issue side and stage-5 result;
// out_valid/out_ready/out_result/out_sign result port.
// Option: FP_MAC_SEQ_PERF_EN adds perf_cycles, cycles from start acceptance to out_valid rise.
module fp_mac_sequencer #(
  parameter int PIPE_DEPTH = fp_mac_pkg::PIPE_DEPTH_DEF,
  parameter int LEN_W = 8,
  parameter int DATA_W = fp_mac_pkg::DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  vec_len,
  output logic              busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              mac_issue,
  output logic [DATA_W-1:0] mac_a,
  output logic [DATA_W-1:0] mac_b,
  output logic              mac_acc_clear,
  input  logic [DATA_W-1:0] mac_result,
  input  logic              mac_sign,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_sign
`ifdef FP_MAC_SEQ_PERF_EN
  ,
  output logic [15:0]       perf_cycles
`endif
);
  import fp_mac_pkg::*;
  state_t state, state_nx;
  logic [LEN_W-1:0] remaining;
  logic first_flag, mac_last, tap_valid, tap_last;
  logic accept, last_acc, capture, job_start;
  assign in_ready  = state == ISSUE;
  assign busy      = state != IDLE;
  assign out_valid = state == DONE;
  assign accept    = in_ready && in_valid;
  assign last_acc  = accept && remaining == LEN_W'(1);
  assign job_start = state == IDLE && start;
  // only the element tagged last may capture; bubbles and earlier elements pass the tap unseen
  assign capture   = state == DRAIN && tap_valid && tap_last;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  state_nx = !start ? IDLE : (vec_len == '0 ? DONE : ISSUE);
      ISSUE: state_nx = last_acc ? DRAIN : ISSUE;
      DRAIN: state_nx = capture ? DONE : DRAIN;
      DONE:  state_nx = out_ready ? IDLE : DONE;
    endcase
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      remaining     <= '0;
      first_flag    <= 1'b0;
      mac_issue     <= 1'b0;
      mac_acc_clear <= 1'b0;
      mac_last      <= 1'b0;
      mac_a         <= '0;
      mac_b         <= '0;
      out_result    <= '0;
      out_sign      <= 1'b0;
    end else begin
      mac_issue     <= accept;
      mac_acc_clear <= accept && first_flag;
      mac_last      <= last_acc;
      if (accept) begin
        mac_a      <= in_a;
        mac_b      <= in_b;
        remaining  <= remaining - 1'b1;
        first_flag <= 1'b0;
      end
      // result is zeroed per job so an empty job reports 0/0
      if (job_start) begin
        remaining  <= vec_len;
        first_flag <= 1'b1;
        out_result <= '0;
        out_sign   <= 1'b0;
      end
      if (capture) begin
        out_result <= mac_result;
        out_sign   <= mac_sign;
      end
    end
  fp_mac_inflight_tracker #(.DEPTH(PIPE_DEPTH)) u_tracker (
    .clock(clock),
    .reset(reset),
    .issue(mac_issue),
    .last(mac_last),
    .tap_valid(tap_valid),
    .tap_last(tap_last)
  );
`ifdef FP_MAC_SEQ_PERF_EN
  // the start cycle itself counts, so the counter opens at 1
  always_ff @(posedge clock or posedge reset)
    if (reset) perf_cycles <= '0;
    else if (job_start) perf_cycles <= 16'd1;
    else if ((state == ISSUE || state == DRAIN) && perf_cycles != 16'hFFFF) perf_cycles <= perf_cycles + 1'b1;
`endif
endmodule

// File: tb/tb_fp_mac_sequencer.sv
// tb_fp_mac_sequencer: randomized self-checking bench with a pipeline stand-in and dot-product model
module tb_fp_mac_sequencer;
  localparam int D = 5;
  logic clock = 0;
  logic reset = 1;
  logic start = 0;
  logic [7:0] vec_len = 0;
  logic busy, in_ready, mac_issue, mac_acc_clear, out_valid, out_sign, mac_sign;
  logic in_valid = 0;
  logic out_ready = 0;
  logic [31:0] in_a = 0, in_b = 0, mac_a, mac_b, mac_result, out_result;
`ifdef FP_MAC_SEQ_PERF_EN
  logic [15:0] perf_cycles;
`endif
  int n_chk = 0, n_fail = 0, cyc = 0, last_acc_cyc = 0;
  logic [31:0] exp_acc;
  int iss_q[$];
  int clr_q[$];
  fp_mac_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .vec_len(vec_len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mac_issue(mac_issue), .mac_a(mac_a), .mac_b(mac_b), .mac_acc_clear(mac_acc_clear),
    .mac_result(mac_result), .mac_sign(mac_sign), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_sign(out_sign)
`ifdef FP_MAC_SEQ_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  // pipeline stand-in: accumulates a*b (wrapping) and emits it D cycles after issue; garbage otherwise
  logic [31:0] pr [D];
  logic        ps [D];
  logic [31:0] acc_m;
  wire  [31:0] acc_nx = (mac_acc_clear ? 32'd0 : acc_m) + mac_a * mac_b;
  always @(posedge clock or posedge reset)
    if (reset) begin
      acc_m <= 0;
      for (int i = 0; i < D; i++) begin pr[i] <= 0; ps[i] <= 0; end
    end else begin
      if (mac_issue) acc_m <= acc_nx;
      for (int i = D - 1; i > 0; i--) begin pr[i] <= pr[i-1]; ps[i] <= ps[i-1]; end
      pr[0] <= mac_issue ? acc_nx : $urandom;
      ps[0] <= mac_issue ? acc_nx[31] : 1'($urandom);
    end
  assign mac_result = pr[D-1];
  assign mac_sign   = ps[D-1];
  always @(negedge clock)
    if (mac_issue) begin
      iss_q.push_back(cyc);
      if (mac_acc_clear) clr_q.push_back(cyc);
    end

  // mode 0: valid held high, 1: alternating, 2: random
  task automatic feed(input int len, input int mode);
    int i, k;
    logic v;
    logic [31:0] a, b;
    iss_q.delete();
    clr_q.delete();
    exp_acc = 0;
    start = 1;
    vec_len = 8'(len);
    @(negedge clock);
    start = 0;
    i = 0;
    k = 0;
    while (i < len && k < 4000) begin
      v = mode == 0 ? 1'b1 : mode == 1 ? (k % 2 == 0) : ($urandom_range(0, 2) != 0);
      a = $urandom;
      b = $urandom;
      in_valid = v;
      in_a = a;
      in_b = b;
      if (v && in_ready) begin
        exp_acc = exp_acc + a * b;
        i++;
        last_acc_cyc = cyc;
      end
      k++;
      @(negedge clock);
    end
    in_valid = 0;
  endtask

  task automatic wait_out(output int lat, output bit seen);
    seen = 0;
    lat = -1;
    for (int t = 0; t < 40; t++) begin
      if (out_valid) begin
        seen = 1;
        lat = cyc - last_acc_cyc;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic handshake();
    out_ready = 1;
    @(negedge clock);
    out_ready = 0;
  endtask

  task automatic test_reset();
    #2;
    n_chk++; if ({busy, in_ready, mac_issue, mac_acc_clear, out_valid, out_sign} !== 6'b0) begin n_fail++; $display("FAIL reset_flags got %b want 000000", {busy, in_ready, mac_issue, mac_acc_clear, out_valid, out_sign}); end
    n_chk++; if ({mac_a, mac_b, out_result} !== 96'b0) begin n_fail++; $display("FAIL reset_data got %h want 0", {mac_a, mac_b, out_result}); end
    repeat (3) @(negedge clock);
    reset = 0;
    @(negedge clock);
    n_chk++; if ({busy, in_ready, out_valid} !== 3'b0) begin n_fail++; $display("FAIL reset_idle got %b want 000", {busy, in_ready, out_valid}); end
  endtask

  task automatic test_vec3();
    int lat, span;
    bit seen;
    feed(3, 0);
    wait_out(lat, seen);
    span = iss_q.size() == 3 ? iss_q[2] - iss_q[0] : -1;
    n_chk++; if (iss_q.size() !== 3) begin n_fail++; $display("FAIL v3_issues got %0d want 3", iss_q.size()); end
    n_chk++; if (span !== 2) begin n_fail++; $display("FAIL v3_consecutive span got %0d want 2", span); end
    n_chk++; if (clr_q.size() !== 1 || iss_q.size() == 0 || clr_q[0] !== iss_q[0]) begin n_fail++; $display("FAIL v3_acc_clear got %0d clears want 1 on first", clr_q.size()); end
    n_chk++; if (!seen || lat !== D + 2) begin n_fail++; $display("FAIL v3_latency got %0d want %0d", lat, D + 2); end
    n_chk++; if (out_result !== exp_acc || out_sign !== exp_acc[31]) begin n_fail++; $display("FAIL v3_result got %h/%b want %h/%b", out_result, out_sign, exp_acc, exp_acc[31]); end
    handshake();
    n_chk++; if (out_valid !== 0 || busy !== 0) begin n_fail++; $display("FAIL v3_to_idle got v=%b busy=%b want 0 0", out_valid, busy); end
  endtask

  task automatic test_toggle();
    int lat, span;
    bit seen;
    feed(4, 1);
    wait_out(lat, seen);
    span = iss_q.size() == 4 ? iss_q[3] - iss_q[0] : -1;
    n_chk++; if (iss_q.size() !== 4 || span !== 6) begin n_fail++; $display("FAIL tog_issues got %0d over span %0d want 4 over 6", iss_q.size(), span); end
    n_chk++; if (clr_q.size() !== 1) begin n_fail++; $display("FAIL tog_acc_clear got %0d want 1", clr_q.size()); end
    n_chk++; if (!seen || lat !== D + 2) begin n_fail++; $display("FAIL tog_latency got %0d want %0d", lat, D + 2); end
    n_chk++; if (out_result !== exp_acc || out_sign !== exp_acc[31]) begin n_fail++; $display("FAIL tog_result got %h/%b want %h/%b", out_result, out_sign, exp_acc, exp_acc[31]); end
    handshake();
  endtask

  task automatic test_zero();
    iss_q.delete();
    out_ready = 1;
    start = 1;
    vec_len = 0;
    @(negedge clock);
    start = 0;
    n_chk++; if (busy !== 1 || out_valid !== 1) begin n_fail++; $display("FAIL zero_done got busy=%b v=%b want 1 1", busy, out_valid); end
    n_chk++; if (out_result !== 0 || out_sign !== 0) begin n_fail++; $display("FAIL zero_result got %h/%b want 0/0", out_result, out_sign); end
    @(negedge clock);
    out_ready = 0;
    n_chk++; if (busy !== 0 || out_valid !== 0) begin n_fail++; $display("FAIL zero_one_cycle got busy=%b v=%b want 0 0", busy, out_valid); end
    n_chk++; if (iss_q.size() !== 0) begin n_fail++; $display("FAIL zero_issues got %0d want 0", iss_q.size()); end
  endtask

  task automatic test_done_hold();
    int lat;
    bit seen;
    feed(2, 2);
    wait_out(lat, seen);
    n_chk++; if (!seen) begin n_fail++; $display("FAIL hold_seen got 0 want 1"); end
    for (int j = 0; j < 5; j++) begin
      start = j == 2;
      vec_len = 3;
      in_valid = j == 2;
      @(negedge clock);
      n_chk++; if (out_valid !== 1 || out_result !== exp_acc || out_sign !== exp_acc[31]) begin n_fail++; $display("FAIL hold_stable cycle %0d got v=%b %h want 1 %h", j, out_valid, out_result, exp_acc); end
    end
    start = 0;
    in_valid = 0;
    handshake();
    n_chk++; if (out_valid !== 0 || busy !== 0) begin n_fail++; $display("FAIL hold_to_idle got v=%b busy=%b want 0 0", out_valid, busy); end
    @(negedge clock);
    n_chk++; if (busy !== 0 || iss_q.size() !== 2) begin n_fail++; $display("FAIL hold_start_ignored got busy=%b issues=%0d want 0 2", busy, iss_q.size()); end
  endtask

  task automatic test_reset_drain();
    int lat;
    bit seen, early;
    feed(4, 0);
    @(negedge clock);
    reset = 1;
    #1;
    n_chk++; if (busy !== 0 || out_valid !== 0 || in_ready !== 0) begin n_fail++; $display("FAIL rst_drain_idle got busy=%b v=%b rdy=%b want 0 0 0", busy, out_valid, in_ready); end
    @(negedge clock);
    reset = 0;
    early = 0;
    repeat (12) begin
      @(negedge clock);
      if (out_valid || busy) early = 1;
    end
    n_chk++; if (early !== 0 || out_result !== 0) begin n_fail++; $display("FAIL rst_drain_no_capture got flag=%b res=%h want 0 0", early, out_result); end
    feed(1, 0);
    wait_out(lat, seen);
    n_chk++; if (!seen || lat !== D + 2 || out_result !== exp_acc || out_sign !== exp_acc[31]) begin n_fail++; $display("FAIL rst_next_job got lat=%0d res=%h want %0d %h", lat, out_result, D + 2, exp_acc); end
    handshake();
  endtask

  task automatic test_random();
    int lat, len;
    bit seen;
    for (int r = 0; r < 5; r++) begin
      len = $urandom_range(1, 6);
      feed(len, 2);
      wait_out(lat, seen);
      n_chk++; if (!seen || lat !== D + 2 || iss_q.size() !== len || clr_q.size() !== 1) begin n_fail++; $display("FAIL rand_job%0d got lat=%0d issues=%0d clears=%0d want %0d %0d 1", r, lat, iss_q.size(), clr_q.size(), D + 2, len); end
      n_chk++; if (out_result !== exp_acc || out_sign !== exp_acc[31]) begin n_fail++; $display("FAIL rand_result%0d got %h/%b want %h/%b", r, out_result, out_sign, exp_acc, exp_acc[31]); end
      handshake();
    end
  endtask

  task automatic test_max_len();
    int lat;
    bit seen;
    feed(255, 0);
    wait_out(lat, seen);
    n_chk++; if (!seen || iss_q.size() !== 255 || clr_q.size() !== 1) begin n_fail++; $display("FAIL max_len got issues=%0d clears=%0d want 255 1", iss_q.size(), clr_q.size()); end
    n_chk++; if (out_result !== exp_acc || lat !== D + 2) begin n_fail++; $display("FAIL max_len_result got %h lat=%0d want %h %0d", out_result, lat, exp_acc, D + 2); end
    handshake();
  endtask

`ifdef FP_MAC_SEQ_PERF_EN
  task automatic test_perf();
    int lat;
    bit seen;
    feed(2, 0);
    wait_out(lat, seen);
    n_chk++; if (!seen || perf_cycles !== 16'(D + 4)) begin n_fail++; $display("FAIL perf_cycles got %0d want %0d", perf_cycles, D + 4); end
    handshake();
  endtask
`endif

  initial begin
    test_reset();
    test_vec3();
    test_toggle();
    test_zero();
    test_done_hold();
    test_reset_drain();
    test_random();
    test_max_len();
`ifdef FP_MAC_SEQ_PERF_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
